conv_mac_array: RTL

Parametrised successor to the two-lane int8 x fp16 MAC path.
- Each beat converts LANES signed int8 activations to fp16 and multiplies each by its own fp16 weight.
- The products are reduced by a pipelined adder tree, and each sum is accumulated over a run-time window of beats, with bias injected on the first beat of the window.
- Emits exactly one valid fp16 result per window, with optional ReLU. Valid/ready handshakes on both sides replace the old clock-driven bias mux.
- Sits between the activation/weight buffers and the output writeback.

---
 rtl/conv_mac_pkg.sv | 98 +++++++++
 rtl/fp16_add_tree.sv | 83 ++++++++
 rtl/conv_mac_array.sv | 118 +++++++++++
 3 files changed

// File: rtl/conv_mac_pkg.sv
// Shared types and fp16 arithmetic for the int8 x fp16 MAC array.
// fp16 helpers round to nearest even, saturate to inf and flush subnormals to signed zero.
package conv_mac_pkg;
    localparam int FP16_W = 16;
    localparam int INT_W  = 8;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;
    localparam logic [FP16_W-1:0] FP16_ONE  = 16'h3C00;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic relu;
    } tag_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // m holds the significand with its leading one at bit 10; g/st are guard and sticky
    function automatic logic [15:0] rnd_pack(input logic s, input int e, input logic [10:0] m,
                                             input logic g, input logic st);
        logic [11:0] r;
        int          ee;
        ee = e;
        r  = {1'b0, m} + {11'h0, g & (st | m[0])};
        if (r[11]) begin
            r  = r >> 1;
            ee = ee + 1;
        end
        if (ee >= 31) return {s, 5'h1f, 10'h0};
        if (ee <= 0)  return {s, 15'h0};
        return {s, ee[4:0], r[9:0]};
    endfunction

    function automatic logic [15:0] i8_to_h(input logic [INT_W-1:0] x);
        logic [7:0]  m;
        logic [17:0] t;
        int          p;
        m = x[7] ? 8'(-x) : x;
        p = 0;
        for (int i = 0; i < 8; i++) if (m[i]) p = i;
        if (m == 8'h0) return FP16_ZERO;
        t = 18'(m) << (10 - p);
        return {x[7], 5'(15 + p), t[9:0]};
    endfunction

    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [21:0] p;
        int          e;
        s = a[15] ^ b[15];
        if (a[14:10] == 5'h0 || b[14:10] == 5'h0) return {s, 15'h0};
        if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return {s, 5'h1f, 10'h0};
        p = {11'h0, 1'b1, a[9:0]} * {11'h0, 1'b1, b[9:0]};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        if (p[21]) return rnd_pack(s, e + 1, p[21:11], p[10], |p[9:0]);
        return rnd_pack(s, e, p[20:10], p[9], |p[8:0]);
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [44:0] sh;
        logic [13:0] ys;
        logic [14:0] s;
        int          e, d, lz;
        if (a[14:10] == 5'h0 && b[14:10] == 5'h0) return {a[15] & b[15], 15'h0};
        if (a[14:10] == 5'h0)  return b;
        if (b[14:10] == 5'h0)  return a;
        if (a[14:10] == 5'h1f) return a;
        if (b[14:10] == 5'h1f) return b;
        if (a[14:0] >= b[14:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        e  = int'(x[14:10]);
        d  = e - int'(y[14:10]);
        // align the smaller operand, folding everything shifted out into the sticky bit
        sh = {1'b1, y[9:0], 34'h0} >> d;
        ys = {sh[44:32], |sh[31:0]};
        if (x[15] == y[15]) begin
            s = {1'b0, 1'b1, x[9:0], 3'b0} + {1'b0, ys};
            if (s[14]) begin
                s = {1'b0, s[14:2], s[1] | s[0]};
                e = e + 1;
            end
        end else begin
            s = {1'b0, 1'b1, x[9:0], 3'b0} - {1'b0, ys};
            if (s == 15'h0) return FP16_ZERO;
            lz = 0;
            for (int i = 0; i < 14; i++) if (s[i]) lz = 13 - i;
            s = s << lz;
            e = e - lz;
        end
        return rnd_pack(x[15], e, s[13:3], s[2], |s[1:0]);
    endfunction
endpackage

// File: rtl/fp16_add_tree.sv
// Pipelined pairwise fp16 reduction: log2(LANES) registered adder levels with tags and a
// side-band word carried alongside; everything holds while i_stall is high.
module fp16_add_reg
    import conv_mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [FP16_W-1:0] i_a,
    input  logic [FP16_W-1:0] i_b,
    output logic [FP16_W-1:0] o_sum
);
    logic [FP16_W-1:0] r_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_sum <= FP16_ZERO;
        else if (i_en) r_sum <= fp16_add(i_a, i_b);
    end

    assign o_sum = r_sum;
endmodule

module fp16_add_tree
    import conv_mac_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_stall,
    input  tag_t                         i_tag,
    input  logic [FP16_W-1:0]            i_side,
    input  logic [LANES-1:0][FP16_W-1:0] i_data,
    output tag_t                         o_tag,
    output logic [FP16_W-1:0]            o_side,
    output logic [FP16_W-1:0]            o_sum,
    output logic                         o_busy
);
    localparam int L = clog2(LANES);

    // heap layout: node n sums children 2n+1 and 2n+2, leaves are the lane inputs
    logic [FP16_W-1:0]        w_node [2*LANES-1];
    tag_t [L:1]               r_tag;
    logic [L:1][FP16_W-1:0]   r_side;

    for (genvar i = 0; i < LANES; i++) begin : g_leaf
        assign w_node[LANES-1+i] = i_data[i];
    end

    for (genvar n = 0; n < LANES-1; n++) begin : g_add
        fp16_add_reg u_add (
            .clk   (clk),
            .rst   (rst),
            .i_en  (~i_stall),
            .i_a   (w_node[2*n+1]),
            .i_b   (w_node[2*n+2]),
            .o_sum (w_node[n])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag  <= '0;
            r_side <= '0;
        end else if (!i_stall) begin
            r_tag[1]  <= i_tag;
            r_side[1] <= i_side;
            for (int k = 2; k <= L; k++) begin
                r_tag[k]  <= r_tag[k-1];
                r_side[k] <= r_side[k-1];
            end
        end
    end

    always_comb begin
        o_busy = 1'b0;
        for (int k = 1; k <= L; k++) o_busy = o_busy | r_tag[k].valid;
    end

    assign o_tag  = r_tag[L];
    assign o_side = r_side[L];
    assign o_sum  = w_node[0];
endmodule

// File: rtl/conv_mac_array.sv
// LANES-wide int8 x fp16 MAC: convert, multiply, tree-reduce, then accumulate over a
// run-time window with bias on the first beat; one fp16 result per window.
module conv_mac_array
    import conv_mac_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int WIN_MAX = 16,
    parameter int CNT_W   = $clog2(WIN_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INT_W*LANES-1:0]  in_data,
    input  logic [FP16_W*LANES-1:0] in_wgt,
    input  logic [CNT_W-1:0]        win_len,
    input  logic [FP16_W-1:0]       bias,
    input  logic                    relu_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [FP16_W-1:0]       out_data,
    output logic                    busy
);
    logic                         r_out_valid, r_relu;
    logic [FP16_W-1:0]            r_out_data, r_acc;
    logic [CNT_W-1:0]             r_cnt, r_len, w_len_in, w_len;
    logic                         w_stall, w_acc, w_first, w_last, w_relu;
    logic [LANES-1:0][FP16_W-1:0] r_s0_act, r_s0_wgt, r_s1_prod;
    tag_t                         r_s0_tag, r_s1_tag, w_t_tag;
    logic [FP16_W-1:0]            r_s0_bias, r_s1_bias, w_t_bias, w_t_sum, w_acc_next;
    logic                         w_tree_busy;

    always_comb begin
        w_len_in = win_len;
        if (win_len == '0)                    w_len_in = CNT_W'(1);
        else if (win_len > CNT_W'(WIN_MAX))   w_len_in = CNT_W'(WIN_MAX);
    end

    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_acc    = in_valid & ~w_stall;
    assign w_first  = (r_cnt == '0);
    // window config is live on the first beat and latched for the rest of the window
    assign w_len    = w_first ? w_len_in : r_len;
    assign w_last   = (r_cnt == w_len - CNT_W'(1));
    assign w_relu   = w_first ? relu_en : r_relu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_len  <= CNT_W'(1);
            r_relu <= 1'b0;
        end else if (w_acc) begin
            if (w_first) begin
                r_len  <= w_len_in;
                r_relu <= relu_en;
            end
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_act  <= '0;
            r_s0_wgt  <= '0;
            r_s1_prod <= '0;
            r_s0_tag  <= '0;
            r_s1_tag  <= '0;
            r_s0_bias <= FP16_ZERO;
            r_s1_bias <= FP16_ZERO;
        end else if (!w_stall) begin
            for (int i = 0; i < LANES; i++) begin
                r_s0_act[i]  <= i8_to_h(in_data[INT_W*i +: INT_W]);
                r_s0_wgt[i]  <= in_wgt[FP16_W*i +: FP16_W];
                r_s1_prod[i] <= fp16_mul(r_s0_act[i], r_s0_wgt[i]);
            end
            r_s0_tag  <= '{valid: w_acc, first: w_first, last: w_last, relu: w_relu};
            r_s1_tag  <= r_s0_tag;
            r_s0_bias <= bias;
            r_s1_bias <= r_s0_bias;
        end
    end

    fp16_add_tree #(.LANES(LANES)) u_tree (
        .clk     (clk),
        .rst     (rst),
        .i_stall (w_stall),
        .i_tag   (r_s1_tag),
        .i_side  (r_s1_bias),
        .i_data  (r_s1_prod),
        .o_tag   (w_t_tag),
        .o_side  (w_t_bias),
        .o_sum   (w_t_sum),
        .o_busy  (w_tree_busy)
    );

    assign w_acc_next = fp16_add(w_t_tag.first ? w_t_bias : r_acc, w_t_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= FP16_ZERO;
            r_out_data  <= FP16_ZERO;
            r_out_valid <= 1'b0;
        end else if (!w_stall) begin
            if (w_t_tag.valid) r_acc <= w_acc_next;
            if (w_t_tag.valid && w_t_tag.last) begin
                r_out_data  <= (w_t_tag.relu && w_acc_next[15]) ? FP16_ZERO : w_acc_next;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_s0_tag.valid | r_s1_tag.valid | w_tree_busy | r_out_valid;
endmodule
